program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the bit width of the program counter and of pc_next.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h00000000, meaning the value loaded into pc on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port pc_next, input, WIDTH bits: the next program-counter value, computed externally (PC+4, branch/jump target, etc.).
REQ-006 The block SHALL have port pc, output, WIDTH bits: the current program-counter value, driven directly from a register.
REQ-007 The block SHALL use one clock; reset SHALL be synchronous and active-high, sampled only on the rising edge of clk.

Function
REQ-008 pc SHALL be a WIDTH-bit register with no combinational path from any input to pc.
REQ-009 On a rising clk edge with reset=1, pc SHALL become RESET_VECTOR, regardless of pc_next.
REQ-010 On a rising clk edge with reset=0, pc SHALL become pc_next exactly, with no masking, alignment or arithmetic applied.
REQ-011 Load latency SHALL be one cycle: a pc_next value present at edge N SHALL be visible on pc immediately after edge N and held until the next edge.
REQ-012 Between rising edges, pc SHALL hold its value; changes on pc_next or reset SHALL have no effect until the next rising edge.
REQ-013 The PC SHALL load on every non-reset cycle; there is no enable or stall input.
REQ-014 When reset and a new pc_next change together, reset SHALL take priority at the next edge.
REQ-015 Any pc_next value, including all-ones and unaligned values, SHALL be loaded unchanged; there is no wrap or overflow logic inside the block.
REQ-016 Before the first rising edge, pc is undefined (X in simulation); the block SHALL NOT rely on an initial value.

Reset
REQ-017 Reset asserted at any time, including mid-operation after many loads, SHALL force pc to RESET_VECTOR on the next rising edge.
REQ-018 pc SHALL stay at RESET_VECTOR on every edge while reset remains high.
REQ-019 On the first rising edge after reset deasserts, pc SHALL load the pc_next value present at that edge.
REQ-020 Reset deassertion SHALL require no recovery cycles.

Verification (10 ns clock, first rising edge at t=5)
REQ-021 A bench SHALL drive reset=1 with pc_next=0x00000010 across the first edge and check that pc=0x00000000, not 0x10.
REQ-022 A bench SHALL drive reset=0 with pc_next=0x00000020 and check that pc=0x00000020 after the next edge.
REQ-023 A bench SHALL drive pc_next=0x00000030 and check that pc=0x00000030 after the next edge, and that pc stays 0x20 before that edge.
REQ-024 A bench SHALL reassert reset=1 with pc_next=0x00000030 held and check that pc=0x00000000 after the next edge, then stays 0 while reset stays high.
REQ-025 A bench SHALL change pc_next between edges, e.g. 0x40 then 0x44 within one cycle, and check that pc changes only at the edge, to the last value, 0x44.
REQ-026 A bench SHALL drive pc_next=0xFFFFFFFF with reset=0, check that pc=0xFFFFFFFF, then drive pc_next=0x00000000 and check that pc=0x00000000.

Source files
------------

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Architectural program-counter register. Each rising clock
//               edge loads the externally computed next PC verbatim; a
//               synchronous active-high reset forces the reset vector
//               instead. There is no enable, stall, alignment or arithmetic
//               inside the block.
//
// Parameters  : WIDTH        - bit width of pc and pc_next
//               RESET_VECTOR - value placed on pc by reset
//
// Ports       : clk     (in)        single clock, rising-edge active
//               reset   (in)        synchronous, active-high reset
//               pc_next (in, WIDTH) next PC value (PC+4, branch/jump target)
//               pc      (out,WIDTH) current PC, driven straight from a flop
//
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(32'h0000_0000)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    // The next-state value is the external next PC taken as-is: any value,
    // including all-ones or unaligned addresses, must pass through untouched.
    always_comb begin
        pc_d = pc_next;
    end

    // Reset is only looked at on the clock edge, so it takes priority over a
    // simultaneous pc_next change and needs no recovery cycle on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Output comes directly from the register: no input-to-output path.
    assign pc = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter
// Description : Directed self-checking bench for program_counter. Two
//               instances share stimulus: one with the default reset vector
//               and one with a non-zero reset vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter;

    localparam int          WIDTH = 32;
    localparam logic [31:0] ALT_RV = 32'h8000_0000;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_rv;

    int checks;
    int errors;

    program_counter #(
        .WIDTH        (WIDTH)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .pc_next (pc_next),
        .pc      (pc)
    );

    program_counter #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (ALT_RV)
    ) u_dut_rv (
        .clk     (clk),
        .reset   (reset),
        .pc_next (pc_next),
        .pc      (pc_rv)
    );

    // 10 ns period, first rising edge at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;

        // Reset across the first edge; pc_next must be ignored.
        reset   = 1'b1;
        pc_next = 32'h0000_0010;
        edge_step();
        check("reset_first_edge", pc, 32'h0000_0000);
        check("reset_vector_alt", pc_rv, ALT_RV);

        // Release reset: loads pc_next on the very first edge.
        reset   = 1'b0;
        pc_next = 32'h0000_0020;
        edge_step();
        check("load_0x20", pc, 32'h0000_0020);
        check("load_0x20_alt", pc_rv, 32'h0000_0020);

        // New pc_next is not visible until the edge.
        pc_next = 32'h0000_0030;
        #3;
        check("hold_before_edge", pc, 32'h0000_0020);
        edge_step();
        check("load_0x30", pc, 32'h0000_0030);

        // Reassert reset with pc_next held; stays at reset vector.
        reset = 1'b1;
        edge_step();
        check("reset_mid_op", pc, 32'h0000_0000);
        check("reset_mid_op_alt", pc_rv, ALT_RV);
        edge_step();
        check("reset_held_1", pc, 32'h0000_0000);
        edge_step();
        check("reset_held_2", pc, 32'h0000_0000);
        check("reset_held_alt", pc_rv, ALT_RV);

        // Deassert: first edge loads pc_next, no recovery cycle.
        reset   = 1'b0;
        pc_next = 32'h0000_0100;
        edge_step();
        check("load_after_reset", pc, 32'h0000_0100);
        check("load_after_reset_alt", pc_rv, 32'h0000_0100);

        // pc_next changes twice within one cycle: only the last one is taken.
        pc_next = 32'h0000_0040;
        #2;
        check("mid_cycle_hold_a", pc, 32'h0000_0100);
        pc_next = 32'h0000_0044;
        #2;
        check("mid_cycle_hold_b", pc, 32'h0000_0100);
        edge_step();
        check("last_value_0x44", pc, 32'h0000_0044);

        // Reset rising between edges does nothing until the edge, and wins
        // over a simultaneous pc_next change.
        reset = 1'b1;
        #2;
        check("reset_no_async", pc, 32'h0000_0044);
        pc_next = 32'h0000_0050;
        edge_step();
        check("reset_priority", pc, 32'h0000_0000);
        reset = 1'b0;

        // Extremes and unaligned values pass through unchanged.
        pc_next = 32'hFFFF_FFFF;
        edge_step();
        check("all_ones", pc, 32'hFFFF_FFFF);
        pc_next = 32'h0000_0000;
        edge_step();
        check("all_zeros", pc, 32'h0000_0000);
        pc_next = 32'h0000_0003;
        edge_step();
        check("unaligned", pc, 32'h0000_0003);
        pc_next = 32'hDEAD_BEEF;
        edge_step();
        check("pattern_deadbeef", pc, 32'hDEAD_BEEF);
        check("pattern_deadbeef_alt", pc_rv, 32'hDEAD_BEEF);
        pc_next = 32'h5555_AAAA;
        edge_step();
        check("pattern_5555aaaa", pc, 32'h5555_AAAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
